// File: rtl/domain_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : domain_rst_seq
// Purpose  : Reset and clock-enable sequencer for a multi-clock system.
//            After reset it walks the domains in index order, enabling each
//            domain clock and then releasing its reset, with a programmable
//            gap between steps. In normal operation it services per-domain
//            software reset requests with an assert / gate / ungate /
//            release handshake, one domain at a time, lowest index first.
// Ports    :
//   clk_i          sequencer clock (always-on reference)
//   rst_i          synchronous active-high reset
//   gap_cfg_i      gap G in clk cycles (0 is treated as 1), latched at the
//                  start of each sequence
//   sw_rst_req_i   per-domain level request, held until its ack pulses
//   dom_rst_n_o    per-domain active-low reset (registered)
//   clk_en_o       per-domain clock enable (registered)
//   sw_rst_ack_o   per-domain one-cycle completion pulse
//   seq_busy_o     high while a power-up or software sequence is running
//   seq_done_o     one-cycle pulse when the power-up sequence completes
// Revision : 1.0 - initial release
// ============================================================================
module domain_rst_seq #(
  parameter int NUM_DOMAINS = 4,
  parameter int GAP_WIDTH   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [GAP_WIDTH-1:0]   gap_cfg_i,
  input  logic [NUM_DOMAINS-1:0] sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] dom_rst_n_o,
  output logic [NUM_DOMAINS-1:0] clk_en_o,
  output logic [NUM_DOMAINS-1:0] sw_rst_ack_o,
  output logic                   seq_busy_o,
  output logic                   seq_done_o
);

  localparam int                 c_IDX_W = $clog2(NUM_DOMAINS);
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    ST_PWR_EN    = 3'd0,
    ST_PWR_REL   = 3'd1,
    ST_RUN       = 3'd2,
    ST_SW_ASSERT = 3'd3,
    ST_SW_GATE   = 3'd4,
    ST_SW_UNGATE = 3'd5
  } state_t;

  state_t                   state_q,     state_d;
  logic [c_IDX_W-1:0]       idx_q,       idx_d;
  logic [GAP_WIDTH-1:0]     cnt_q,       cnt_d;
  logic [GAP_WIDTH-1:0]     gap_q,       gap_d;
  logic [NUM_DOMAINS-1:0]   dom_rst_n_q, dom_rst_n_d;
  logic [NUM_DOMAINS-1:0]   clk_en_q,    clk_en_d;
  logic [NUM_DOMAINS-1:0]   ack_q,       ack_d;
  logic                     busy_q,      busy_d;
  logic                     done_q,      done_d;

  logic [GAP_WIDTH-1:0]     w_gap_sel;
  logic [GAP_WIDTH-1:0]     w_gap_sel_m1;
  logic [GAP_WIDTH-1:0]     w_gap_m1;
  logic                     w_cnt_zero;
  logic                     w_req_any;
  logic [c_IDX_W-1:0]       w_req_idx;

  // A zero configuration still means a one-cycle gap.
  assign w_gap_sel    = (gap_cfg_i == '0) ? GAP_WIDTH'(1) : gap_cfg_i;
  assign w_gap_sel_m1 = w_gap_sel - GAP_WIDTH'(1);
  assign w_gap_m1     = gap_q - GAP_WIDTH'(1);
  assign w_cnt_zero   = (cnt_q == '0);
  assign w_req_any    = |sw_rst_req_i;

  // Fixed-priority encoder: scanning downward lets the lowest set bit win.
  always_comb begin
    w_req_idx = '0;
    for (int k = NUM_DOMAINS - 1; k >= 0; k--) begin
      if (sw_rst_req_i[k]) begin
        w_req_idx = c_IDX_W'(k);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_PWR_EN;
      idx_q       <= '0;
      cnt_q       <= '0;
      gap_q       <= GAP_WIDTH'(1);
      dom_rst_n_q <= '0;
      clk_en_q    <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      dom_rst_n_q <= dom_rst_n_d;
      clk_en_q    <= clk_en_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and next-output logic. Each timed step waits until the gap
  // counter reaches zero, performs its action and reloads the counter with
  // G-1, so consecutive actions land exactly G edges apart.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    dom_rst_n_d = dom_rst_n_q;
    clk_en_d    = clk_en_q;
    ack_d       = '0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (!w_cnt_zero) begin
      cnt_d = cnt_q - GAP_WIDTH'(1);
    end

    case (state_q)
      ST_PWR_EN: begin
        if (w_cnt_zero) begin
          // Index 0 in this state only occurs on the first cycle out of
          // reset, which is where the power-up gap is captured.
          if (idx_q == '0) begin
            gap_d = w_gap_sel;
            cnt_d = w_gap_sel_m1;
          end else begin
            cnt_d = w_gap_m1;
          end
          clk_en_d[idx_q] = 1'b1;
          state_d         = ST_PWR_REL;
        end
      end

      ST_PWR_REL: begin
        if (w_cnt_zero) begin
          dom_rst_n_d[idx_q] = 1'b1;
          if (idx_q == c_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_RUN;
          end else begin
            idx_d   = idx_q + c_IDX_W'(1);
            cnt_d   = w_gap_m1;
            state_d = ST_PWR_EN;
          end
        end
      end

      ST_RUN: begin
        // Skipping arbitration while an ack is out gives the finished
        // requester one cycle to drop its request before it could win again.
        if ((ack_q == '0) && w_req_any) begin
          idx_d                  = w_req_idx;
          gap_d                  = w_gap_sel;
          cnt_d                  = w_gap_sel_m1;
          dom_rst_n_d[w_req_idx] = 1'b0;
          busy_d                 = 1'b1;
          state_d                = ST_SW_ASSERT;
        end
      end

      ST_SW_ASSERT: begin
        if (w_cnt_zero) begin
          clk_en_d[idx_q] = 1'b0;
          cnt_d           = w_gap_m1;
          state_d         = ST_SW_GATE;
        end
      end

      ST_SW_GATE: begin
        if (w_cnt_zero) begin
          clk_en_d[idx_q] = 1'b1;
          cnt_d           = w_gap_m1;
          state_d         = ST_SW_UNGATE;
        end
      end

      ST_SW_UNGATE: begin
        if (w_cnt_zero) begin
          dom_rst_n_d[idx_q] = 1'b1;
          ack_d[idx_q]       = 1'b1;
          busy_d             = 1'b0;
          state_d            = ST_RUN;
        end
      end

      default: begin
        state_d = ST_PWR_EN;
      end
    endcase
  end

  assign dom_rst_n_o  = dom_rst_n_q;
  assign clk_en_o     = clk_en_q;
  assign sw_rst_ack_o = ack_q;
  assign seq_busy_o   = busy_q;
  assign seq_done_o   = done_q;

endmodule
`default_nettype wire

// File: doc/domain_rst_seq.md
# domain_rst_seq

Reset and clock-enable sequencer for the multi-clock system. It releases the per-domain resets and clock enables of up to NUM_DOMAINS clock domains in fixed index order with a programmable gap. In normal operation it services per-domain software reset requests with an assert / gate / ungate / release handshake. Its DOM_RST_N outputs drive the active-low RST inputs of each domain's 2-stage reset synchronizer. Its CLK_EN outputs drive the domain clock gates.

## Interface
- NUM_DOMAINS, default 4: number of sequenced domains; allowed range 2..8.
- GAP_WIDTH, default 8: width of the gap counter and of GAP_CFG.

- CLK  input  1: sequencer clock (always-on reference clock).
- RST  input  1: reset, synchronous, active-high.
- GAP_CFG  input  GAP_WIDTH: gap G in CLK cycles. G = 1 when GAP_CFG = 0. G is latched at sequence start.
- SW_RST_REQ  input  NUM_DOMAINS: level request per domain. Held by the requester until its ACK bit pulses.
- DOM_RST_N  output  NUM_DOMAINS: active-low domain reset, registered.
- CLK_EN  output  NUM_DOMAINS: domain clock enable, registered.
- SW_RST_ACK  output  NUM_DOMAINS: one-cycle completion pulse per domain.
- SEQ_BUSY  output  1: high whenever any sequence (power-up or software) is in progress.
- SEQ_DONE  output  1: one-cycle pulse at the end of the power-up sequence.

## Operation
- Reset values: DOM_RST_N = 0, CLK_EN = 0, SW_RST_ACK = 0, SEQ_DONE = 0, SEQ_BUSY = 1, state PWR_EN, domain index = 0, gap counter = 0.
- States: PWR_EN, PWR_REL, RUN, SW_ASSERT, SW_GATE, SW_UNGATE.
- Power-up sequence:
  - On the first edge with RST low, latch G from GAP_CFG and set CLK_EN[0].
  - Then alternate PWR_REL and PWR_EN, spending G cycles per step.
  - PWR_REL sets DOM_RST_N[i]. PWR_EN sets CLK_EN[i+1].
  - After DOM_RST_N[NUM_DOMAINS-1] is set, go to RUN, pulse SEQ_DONE and clear SEQ_BUSY.
- RUN:
  - A grant is evaluated only on cycles where SW_RST_ACK = 0.
  - The lowest-index set bit of SW_RST_REQ wins (fixed priority).
  - On grant: latch G, clear DOM_RST_N[i], set SEQ_BUSY, enter SW_ASSERT.
- Software reset of domain i:
  - SW_ASSERT, G cycles: reset asserted with the clock running; then clear CLK_EN[i].
  - SW_GATE, G cycles: then set CLK_EN[i].
  - SW_UNGATE, G cycles: then set DOM_RST_N[i], pulse SW_RST_ACK[i], clear SEQ_BUSY, return to RUN.
- Domains other than the granted one keep their outputs constant throughout.
- Boundary conditions:
  - Requests raised during the power-up sequence or a software sequence stay pending and are arbitrated in RUN.
  - A requester must drop its bit in the cycle SW_RST_ACK is high.
  - GAP_CFG changes mid-sequence are ignored until the next latch point.
  - RST high in any state, including mid-sequence: all outputs and state return to reset values at that edge. The power-up sequence restarts from domain 0 once RST goes low.
- Widths:
  - Gap counter: GAP_WIDTH bits, counts G-1 down to 0; no wrap.
  - Domain index: $clog2(NUM_DOMAINS) bits; stops at NUM_DOMAINS-1.

## Timing
- E1 = first rising edge with RST sampled low. All edges below are counted from E1.
- Power-up sequence:
  - CLK_EN[i] rises at E1 + 2iG.
  - DOM_RST_N[i] rises at E1 + (2i+1)G.
  - SEQ_DONE is high for the one cycle after edge E1 + (2N-1)G; SEQ_BUSY falls at that same edge.
  - Total power-up latency: (2N-1)G edges.
- Software reset, with the grant at edge T:
  - DOM_RST_N[i] falls at T.
  - CLK_EN[i] falls at T+G and rises at T+2G.
  - DOM_RST_N[i] rises and SW_RST_ACK[i] pulses at T+3G.
  - The next grant is possible no earlier than T+3G+2.
- Earliest software grant after power-up: E1 + (2N-1)G + 1.

## Test plan
- Power-up, N=4, GAP_CFG=3:
  - CLK_EN rises at E1+0/6/12/18.
  - DOM_RST_N rises at E1+3/9/15/21.
  - SEQ_DONE is a single pulse after E1+21; SEQ_BUSY is low afterwards.
- GAP_CFG=0: G=1. DOM_RST_N[3] rises at E1+7 and SEQ_DONE follows.
- SW_RST_REQ=0b0100, G=4, grant at T:
  - DOM_RST_N[2] low at T; CLK_EN[2] low at T+4 and high at T+8.
  - DOM_RST_N[2] high with ACK[2] at T+12.
  - Bits 0, 1 and 3 stay stable.
- SW_RST_REQ=0b1010 with G=2:
  - Domain 1 completes at T+6.
  - Domain 3 is granted at T+8 and completes at T+14.
  - ACK[1] and ACK[3] are each exactly one cycle wide.
- Reset and ordering corner cases:
  - Request domain 0 during the power-up sequence: it is granted at the first RUN evaluation edge after SEQ_DONE.
  - Change GAP_CFG mid-sequence: no timing change.
  - Raise RST at T+5 during a software sequence: all outputs return to reset values at that edge, and power-up restarts after RST drops.
